// File: rtl/lc3_memaccess_seq.sv
// rtl/lc3_memaccess_seq.sv - LC-3 MEM-stage LD/LDR/ST/STR/LDI/STI sequencer over a req/ack data port
// Optional per-request timeout abort is enabled by defining LC3_MEMACC_TIMEOUT_EN.
module lc3_memaccess_seq #(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          M_Write,
  input  logic          M_Control,
  input  logic [AW-1:0] M_Addr,
  input  logic [DW-1:0] M_Data,
  output logic          DMem_req,
  input  logic          DMem_ack,
  output logic [AW-1:0] DMem_addr,
  output logic          DMem_rd,
  output logic [DW-1:0] DMem_din,
  input  logic [DW-1:0] DMem_dout,
  output logic [DW-1:0] memout,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_PTR, S_ACC, S_DONE} state_t;

  state_t        r_state, w_state_nx;
  logic          r_req, w_req_nx;
  logic          r_rd, w_rd_nx;
  logic [AW-1:0] r_addr, w_addr_nx;
  logic [DW-1:0] r_din, w_din_nx;
  logic [DW-1:0] r_memout, w_memout_nx;
  logic          r_done, w_done_nx;
  logic          r_err, w_err_nx;
  logic          r_write, w_write_nx;
  logic [DW-1:0] r_data, w_data_nx;
  logic [AW-1:0] w_ptr;
  logic          w_timeout;

  // Fetched pointer is truncated or zero-extended to the address width.
  generate
    if (DW >= AW) begin : g_ptr_trunc
      assign w_ptr = DMem_dout[AW-1:0];
    end else begin : g_ptr_zext
      assign w_ptr = {{(AW-DW){1'b0}}, DMem_dout};
    end
  endgenerate

`ifdef LC3_MEMACC_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_wait, w_wait_nx;

  // Counter restarts with every new request, including the PTR->ACC handoff.
  always_comb begin
    w_wait_nx = '0;
    if ((r_state == S_PTR || r_state == S_ACC) && !DMem_ack)
      w_wait_nx = r_wait + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wait <= '0;
    else        r_wait <= w_wait_nx;
  end

  assign w_timeout = (r_wait == WAIT_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_req_nx    = r_req;
    w_rd_nx     = r_rd;
    w_addr_nx   = r_addr;
    w_din_nx    = r_din;
    w_memout_nx = r_memout;
    w_write_nx  = r_write;
    w_data_nx   = r_data;
    w_done_nx   = 1'b0;
    w_err_nx    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_write_nx = M_Write;
          w_data_nx  = M_Data;
          w_req_nx   = 1'b1;
          w_addr_nx  = M_Addr;
          if (M_Control) begin
            w_state_nx = S_PTR;
            w_rd_nx    = 1'b1;
            w_din_nx   = '0;
          end else begin
            w_state_nx = S_ACC;
            w_rd_nx    = !M_Write;
            w_din_nx   = M_Write ? M_Data : '0;
          end
        end
      end
      S_PTR: begin
        if (DMem_ack) begin
          w_state_nx = S_ACC;
          w_rd_nx    = !r_write;
          w_addr_nx  = w_ptr;
          w_din_nx   = r_write ? r_data : '0;
        end else if (w_timeout) begin
          w_state_nx = S_IDLE;
          w_req_nx   = 1'b0;
          w_rd_nx    = 1'b1;
          w_din_nx   = '0;
          w_done_nx  = 1'b1;
          w_err_nx   = 1'b1;
        end
      end
      S_ACC: begin
        if (DMem_ack) begin
          if (!r_write) w_memout_nx = DMem_dout;
          w_state_nx = S_DONE;
          w_req_nx   = 1'b0;
          w_rd_nx    = 1'b1;
          w_din_nx   = '0;
          w_done_nx  = 1'b1;
        end else if (w_timeout) begin
          w_state_nx = S_IDLE;
          w_req_nx   = 1'b0;
          w_rd_nx    = 1'b1;
          w_din_nx   = '0;
          w_done_nx  = 1'b1;
          w_err_nx   = 1'b1;
        end
      end
      S_DONE: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_rd     <= 1'b1;
      r_addr   <= '0;
      r_din    <= '0;
      r_memout <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_write  <= 1'b0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_req    <= w_req_nx;
      r_rd     <= w_rd_nx;
      r_addr   <= w_addr_nx;
      r_din    <= w_din_nx;
      r_memout <= w_memout_nx;
      r_done   <= w_done_nx;
      r_err    <= w_err_nx;
      r_write  <= w_write_nx;
      r_data   <= w_data_nx;
    end
  end

  assign DMem_req  = r_req;
  assign DMem_rd   = r_rd;
  assign DMem_addr = r_addr;
  assign DMem_din  = r_din;
  assign memout    = r_memout;
  assign done      = r_done;
  assign err       = r_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_lc3_memaccess_seq.sv
// tb/tb_lc3_memaccess_seq.sv - directed self-checking bench for lc3_memaccess_seq
// Build with LC3_MEMACC_TIMEOUT_EN to also exercise the timeout abort (TIMEOUT_CYC=4).
`timescale 1ns/1ps
module tb_lc3_memaccess_seq;

`ifdef LC3_MEMACC_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        M_Write = 1'b0;
  logic        M_Control = 1'b0;
  logic [15:0] M_Addr = '0;
  logic [15:0] M_Data = '0;
  logic        DMem_req;
  logic        DMem_ack = 1'b0;
  logic [15:0] DMem_addr;
  logic        DMem_rd;
  logic [15:0] DMem_din;
  logic [15:0] DMem_dout = '0;
  logic [15:0] memout;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  lc3_memaccess_seq #(.DW(16), .AW(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .M_Write(M_Write),
    .M_Control(M_Control), .M_Addr(M_Addr), .M_Data(M_Data),
    .DMem_req(DMem_req), .DMem_ack(DMem_ack), .DMem_addr(DMem_addr),
    .DMem_rd(DMem_rd), .DMem_din(DMem_din), .DMem_dout(DMem_dout),
    .memout(memout), .busy(busy), .done(done), .err(err)
  );

  logic [15:0] mem [0:65535];
  int wait_cfg = 0;
  bit ack_never = 1'b0;
  int wcnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  int          dk, nd, rc, un, ne, ek;
  logic [15:0] fa, la, ldin;
  logic        lrd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory responds wait_cfg cycles after a request is seen; ack drives away from the edge.
  task mem_model;
    forever begin
      @(posedge clk);
      #1;
      DMem_ack = 1'b0;
      if (DMem_req && rst_n) begin
        if (!ack_never && wcnt >= wait_cfg) begin
          DMem_ack = 1'b1;
          wcnt = 0;
          if (DMem_rd) DMem_dout = mem[DMem_addr];
          else         mem[DMem_addr] = DMem_din;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  endtask

  task automatic run_op(input bit wr, input bit ind, input logic [15:0] addr,
                        input logic [15:0] data, input int extra_k,
                        output int done_k, output int n_done, output int req_cyc,
                        output logic [15:0] first_addr, output logic [15:0] last_addr,
                        output logic [15:0] last_din, output logic last_rd,
                        output int unstable, output int n_err, output int err_k);
    logic [15:0] pa, pd;
    logic        prd, preq, pack;
    done_k = -1; n_done = 0; req_cyc = 0; unstable = 0; n_err = 0; err_k = -1;
    first_addr = '0; last_addr = '0; last_din = '0; last_rd = 1'b0;
    pa = '0; pd = '0; prd = 1'b0; preq = 1'b0; pack = 1'b0;
    @(negedge clk);
    start = 1'b1; M_Write = wr; M_Control = ind; M_Addr = addr; M_Data = data;
    @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      start = (k == extra_k);
      if (DMem_req) begin
        req_cyc++;
        if (req_cyc == 1) first_addr = DMem_addr;
        if (preq && !pack && (DMem_addr !== pa || DMem_din !== pd || DMem_rd !== prd))
          unstable++;
        if (DMem_ack) begin
          last_addr = DMem_addr;
          last_din  = DMem_din;
          last_rd   = DMem_rd;
        end
      end
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (err) begin
        n_err++;
        if (err_k < 0) err_k = k;
      end
      preq = DMem_req; pack = DMem_ack; pa = DMem_addr; pd = DMem_din; prd = DMem_rd;
      if (done_k > 0 && k >= done_k + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    fork
      mem_model();
    join_none

    repeat (2) @(negedge clk);
    check("rst_req", DMem_req, 0);
    check("rst_rd", DMem_rd, 1);
    check("rst_addr", DMem_addr, 16'h0000);
    check("rst_din", DMem_din, 16'h0000);
    check("rst_memout", memout, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    mem[16'h3000] = 16'hBEEF;
    wait_cfg = 0;
    run_op(1'b0, 1'b0, 16'h3000, 16'h0000, 0, dk, nd, rc, fa, la, ldin, lrd, un, ne, ek);
    check("ld_done_k", dk, 2);
    check("ld_ndone", nd, 1);
    check("ld_req_cyc", rc, 1);
    check("ld_addr", fa, 16'h3000);
    check("ld_rd", lrd, 1);
    check("ld_memout", memout, 16'hBEEF);
    check("ld_busy_after", busy, 0);
    check("ld_err", ne, 0);

    wait_cfg = 3;
    run_op(1'b1, 1'b0, 16'h4000, 16'h1234, 0, dk, nd, rc, fa, la, ldin, lrd, un, ne, ek);
    check("st_done_k", dk, 5);
    check("st_req_cyc", rc, 4);
    check("st_stable", un, 0);
    check("st_addr", la, 16'h4000);
    check("st_din", ldin, 16'h1234);
    check("st_rd", lrd, 0);
    check("st_mem", mem[16'h4000], 16'h1234);
    check("st_memout", memout, 16'hBEEF);
    check("st_err", ne, 0);

    mem[16'h3000] = 16'h5000;
    mem[16'h5000] = 16'hCAFE;
    wait_cfg = 0;
    run_op(1'b0, 1'b1, 16'h3000, 16'h0000, 0, dk, nd, rc, fa, la, ldin, lrd, un, ne, ek);
    check("ldi_done_k", dk, 3);
    check("ldi_req_cyc", rc, 2);
    check("ldi_ptr_addr", fa, 16'h3000);
    check("ldi_acc_addr", la, 16'h5000);
    check("ldi_memout", memout, 16'hCAFE);

    mem[16'h3000] = 16'h6000;
    mem[16'h6000] = 16'h0000;
    run_op(1'b1, 1'b1, 16'h3000, 16'hAAAA, 3, dk, nd, rc, fa, la, ldin, lrd, un, ne, ek);
    check("sti_mem", mem[16'h6000], 16'hAAAA);
    check("sti_ndone", nd, 1);
    check("sti_done_k", dk, 3);
    check("sti_acc_addr", la, 16'h6000);
    check("sti_memout", memout, 16'hCAFE);

    mem[16'h3100] = 16'h5100;
    mem[16'h5100] = 16'h7E57;
    wait_cfg = 2;
    run_op(1'b0, 1'b1, 16'h3100, 16'h0000, 0, dk, nd, rc, fa, la, ldin, lrd, un, ne, ek);
    check("ldiw_done_k", dk, 7);
    check("ldiw_req_cyc", rc, 6);
    check("ldiw_stable", un, 0);
    check("ldiw_memout", memout, 16'h7E57);

    wait_cfg = 10;
    @(negedge clk);
    start = 1'b1; M_Write = 1'b0; M_Control = 1'b1; M_Addr = 16'h3000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rstp_in_ptr", {busy, DMem_req}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("rstp_req", DMem_req, 0);
    check("rstp_rd", DMem_rd, 1);
    check("rstp_memout", memout, 16'h0000);
    check("rstp_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cfg = 0;
    run_op(1'b0, 1'b0, 16'h3000, 16'h0000, 0, dk, nd, rc, fa, la, ldin, lrd, un, ne, ek);
    check("rstp_next_done_k", dk, 2);
    check("rstp_next_memout", memout, 16'h6000);

`ifdef LC3_MEMACC_TIMEOUT_EN
    ack_never = 1'b1;
    run_op(1'b0, 1'b0, 16'h7000, 16'h0000, 0, dk, nd, rc, fa, la, ldin, lrd, un, ne, ek);
    check("to_done_k", dk, 5);
    check("to_err_k", ek, 5);
    check("to_nerr", ne, 1);
    check("to_memout", memout, 16'h6000);
    check("to_busy_after", busy, 0);
    check("to_req_after", DMem_req, 0);
    ack_never = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
